// File: rtl/jtpopeye_objshift_pkg.sv
// jtpopeye_objshift_pkg: shared FSM states and default geometry for the object shifter
package jtpopeye_objshift_pkg;
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    localparam int DEF_PLANES = 2;
    localparam int DEF_PW     = 16;
    localparam int DEF_CW     = 3;
    localparam int DEF_AW     = 13;
endpackage

// File: rtl/jtpopeye_objshift_plane.sv
// jtpopeye_objshift_plane: one bit plane, pending word plus active bidirectional shifter
module jtpopeye_objshift_plane #(
    parameter int PW = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_pend,
    input  logic          xfer,
    input  logic          clr,
    input  logic          shift,
    input  logic          hflip,
    input  logic [PW-1:0] rom_bits,
    output logic          msb,
    output logic          lsb
);
    logic [PW-1:0] pend_q, pend_d, act_q, act_d;
    always_comb begin
        pend_d = ld_pend ? rom_bits : pend_q;
        act_d  = clr ? '0 : xfer ? pend_q : shift ? (hflip ? act_q << 1 : act_q >> 1) : act_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end
    assign msb = act_q[PW-1];
    assign lsb = act_q[0];
endmodule

// File: rtl/jtpopeye_objshift.sv
// jtpopeye_objshift: object line shifter with ROM fetch FSM; JTPOPEYE_OBJSHIFT_DBLW_EN enables double-width pixels
module jtpopeye_objshift
    import jtpopeye_objshift_pkg::*;
#(
    parameter int PLANES = DEF_PLANES,
    parameter int PW     = DEF_PW,
    parameter int CW     = DEF_CW,
    parameter int AW     = DEF_AW
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pxl_cen,
    input  logic                 hb,
    input  logic                 vb,
    input  logic                 load,
    input  logic [AW-1:0]        attr_code,
    input  logic [CW-1:0]        attr_pal,
    input  logic                 attr_hflip,
    output logic [AW-1:0]        rom_addr,
    output logic                 rom_cs,
    input  logic                 rom_ok,
    input  logic [PLANES*PW-1:0] rom_data,
    output logic [CW-1:0]        pxl_pal,
    output logic [PLANES-1:0]    pxl_v,
    output logic                 underrun,
    output logic                 drop
);
    localparam int CNTW = $clog2(PW);
    localparam logic [CNTW-1:0] LAST = CNTW'(PW - 1);
    state_t st_q, st_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [CW-1:0] pend_pal_q, pend_pal_d, pal_q, pal_d, pxl_pal_q, pxl_pal_d;
    logic pend_hflip_q, pend_hflip_d, hflip_q, hflip_d, pend_valid_q, pend_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PLANES-1:0] pxl_v_q, pxl_v_d, msb, lsb;
    logic underrun_q, underrun_d, drop_q, drop_d;
    logic fire, got, adv, bnd, shift, xfer, clr;
`ifdef JTPOPEYE_OBJSHIFT_DBLW_EN
    logic tog_q, tog_d;
    always_comb begin
        adv   = pxl_cen & tog_q;
        bnd   = adv & (cnt_q == LAST) & ~hb;
        tog_d = (hb | bnd) ? 1'b0 : pxl_cen ? ~tog_q : tog_q;
    end
    always_ff @(posedge clk) tog_q <= rst ? 1'b0 : tog_d;
`else
    always_comb begin
        adv = pxl_cen;
        bnd = pxl_cen & (cnt_q == LAST) & ~hb;
    end
`endif
    // hb flushes everything and outranks both a new load and a returning rom_ok
    always_comb begin
        fire         = pxl_cen & load & ~hb & (st_q == ST_IDLE) & ~pend_valid_q;
        got          = ~hb & (st_q == ST_WAIT) & rom_ok;
        shift        = adv & ~bnd & ~hb;
        xfer         = bnd & pend_valid_q;
        clr          = hb | (bnd & ~pend_valid_q);
        st_d         = hb ? ST_IDLE : fire ? ST_WAIT : got ? ST_IDLE : st_q;
        rom_addr_d   = fire ? attr_code : rom_addr_q;
        pend_pal_d   = fire ? attr_pal : pend_pal_q;
        pend_hflip_d = fire ? attr_hflip : pend_hflip_q;
        pend_valid_d = hb ? 1'b0 : got ? 1'b1 : xfer ? 1'b0 : pend_valid_q;
        pal_d        = xfer ? pend_pal_q : pal_q;
        hflip_d      = xfer ? pend_hflip_q : hflip_q;
        cnt_d        = hb ? LAST : bnd ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
        underrun_d   = bnd & ~pend_valid_q;
        drop_d       = pxl_cen & load & ~hb & ~fire;
        pxl_v_d      = vb ? '0 : hflip_q ? msb : lsb;
        pxl_pal_d    = pal_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            rom_addr_q   <= '0;
            pend_pal_q   <= '0;
            pend_hflip_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pal_q        <= '0;
            hflip_q      <= 1'b0;
            cnt_q        <= LAST;
            underrun_q   <= 1'b0;
            drop_q       <= 1'b0;
            pxl_v_q      <= '0;
            pxl_pal_q    <= '0;
        end else begin
            st_q         <= st_d;
            rom_addr_q   <= rom_addr_d;
            pend_pal_q   <= pend_pal_d;
            pend_hflip_q <= pend_hflip_d;
            pend_valid_q <= pend_valid_d;
            pal_q        <= pal_d;
            hflip_q      <= hflip_d;
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            drop_q       <= drop_d;
            pxl_v_q      <= pxl_v_d;
            pxl_pal_q    <= pxl_pal_d;
        end
    end
    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        jtpopeye_objshift_plane #(.PW(PW)) u_plane (
            .clk      (clk),
            .rst      (rst),
            .ld_pend  (got),
            .xfer     (xfer),
            .clr      (clr),
            .shift    (shift),
            .hflip    (hflip_q),
            .rom_bits (rom_data[p*PW +: PW]),
            .msb      (msb[p]),
            .lsb      (lsb[p])
        );
    end
    assign rom_addr = rom_addr_q;
    assign rom_cs   = (st_q == ST_WAIT);
    assign pxl_pal  = pxl_pal_q;
    assign pxl_v    = pxl_v_q;
    assign underrun = underrun_q;
    assign drop     = drop_q;
endmodule

// File: tb/tb_jtpopeye_objshift.sv
// tb_jtpopeye_objshift: scoreboard bench for the object shifter, pixel-per-pxl_cen expectations
module tb_jtpopeye_objshift;
    localparam int PW = 16;
`ifdef JTPOPEYE_OBJSHIFT_DBLW_EN
    localparam int R = 2;
`else
    localparam int R = 1;
`endif
    localparam int GS = PW * R;
    localparam int L  = R - 1;
    logic clk = 0, rst = 1, pxl_cen = 0, hb = 0, vb = 0, load = 0, attr_hflip = 0, rom_ok = 0;
    logic [12:0] attr_code = '0, rom_addr;
    logic [2:0] attr_pal = '0, pxl_pal;
    logic [31:0] rom_data = '0;
    logic rom_cs, underrun, drop;
    logic [1:0] pxl_v;
    int vectors = 0, errors = 0, und_cnt = 0, drop_cnt = 0, cs_cnt = 0;
    logic cen_p1 = 0, cen_p2 = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_e;
    logic [2:0] cur_pal = '0;
    always #5 clk = ~clk;
    jtpopeye_objshift dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hb(hb), .vb(vb), .load(load),
        .attr_code(attr_code), .attr_pal(attr_pal), .attr_hflip(attr_hflip),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .pxl_pal(pxl_pal), .pxl_v(pxl_v), .underrun(underrun), .drop(drop)
    );
    always @(posedge clk) begin
        cen_p1 <= pxl_cen;
        cen_p2 <= cen_p1;
    end
    // the pixel for a pxl_cen edge appears registered one clk later
    always @(negedge clk) begin
        if (underrun === 1'b1) und_cnt++;
        if (drop === 1'b1) drop_cnt++;
        if (rom_cs === 1'b1) cs_cnt++;
        if (cen_p2 === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got pal=%0d v=%b with no expectation queued", pxl_pal, pxl_v);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pxl_pal, pxl_v} !== mon_e) begin
                    errors++;
                    $display("FAIL pixel got pal=%0d v=%b exp pal=%0d v=%b", pxl_pal, pxl_v, mon_e[4:2], mon_e[1:0]);
                end
            end
        end
    end
    function automatic logic [1:0] pix_at(input logic [31:0] d, input logic f, input int j);
        int b;
        b = f ? PW - 1 - j : j;
        return {d[PW + b], d[b]};
    endfunction
    task automatic push_part(input logic [31:0] d, input logic f, input logic [2:0] p, input int n);
        for (int c = 0; c < n; c++) exp_q.push_back({p, pix_at(d, f, c / R)});
        cur_pal = p;
    endtask
    task automatic push_zero(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back({cur_pal, 2'b00});
    endtask
    task automatic ld_attr(input logic [12:0] c, input logic [2:0] p, input logic f);
        attr_code  = c;
        attr_pal   = p;
        attr_hflip = f;
    endtask
    task automatic step(input logic ld, input logic ok0, input logic ok1);
        pxl_cen = 1; load = ld; rom_ok = ok0;
        @(negedge clk);
        pxl_cen = 0; load = 0; rom_ok = ok1;
        @(negedge clk);
        rom_ok = 0;
        #1;
    endtask
    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        vectors++; if (pxl_v !== 2'b00) begin errors++; $display("FAIL rst_pxl_v got %b exp 00", pxl_v); end
        vectors++; if (pxl_pal !== 3'd0) begin errors++; $display("FAIL rst_pxl_pal got %0d exp 0", pxl_pal); end
        vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rst_rom_cs got %b exp 0", rom_cs); end
        vectors++; if (rom_addr !== 13'h0) begin errors++; $display("FAIL rst_rom_addr got %h exp 0", rom_addr); end
        vectors++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", drop); end
    endtask
    task automatic test_basic;
        int u0;
        push_zero(L + GS);
        ld_attr(13'h0A5, 3'd5, 1'b0);
        rom_data = 32'hFFFF_0001;
        for (int i = 0; i < L; i++) step(0, 0, 0);
        u0 = und_cnt;
        for (int i = 0; i < GS; i++) begin
            step(i == 0, 0, i == 1);
            if (i == 0) begin
                vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL basic_cs got %b exp 1", rom_cs); end
                vectors++; if (rom_addr !== 13'h0A5) begin errors++; $display("FAIL basic_addr got %h exp 0a5", rom_addr); end
            end
            if (i == 1) begin
                vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL basic_cs_release got %b exp 0", rom_cs); end
            end
        end
        vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL basic_first_underrun got %0d exp 1", und_cnt - u0); end
        push_part(32'hFFFF_0001, 1'b0, 3'd5, GS);
    endtask
    task automatic test_flip;
        int u0, d0;
        u0 = und_cnt; d0 = drop_cnt;
        ld_attr(13'h0B6, 3'd2, 1'b1);
        for (int i = 0; i < GS; i++) step(i == 1, i == 3, 0);
        vectors++; if (und_cnt - u0 !== 0) begin errors++; $display("FAIL flip_underrun got %0d exp 0", und_cnt - u0); end
        vectors++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL flip_drop got %0d exp 0", drop_cnt - d0); end
        push_part(32'hFFFF_0001, 1'b1, 3'd2, GS);
    endtask
    task automatic test_underrun;
        int u0, c0;
        u0 = und_cnt; c0 = cs_cnt;
        push_zero(GS);
        for (int i = 0; i < GS; i++) step(0, 0, 0);
        vectors++; if (und_cnt - u0 !== 0) begin errors++; $display("FAIL urun_loaded_group got %0d exp 0", und_cnt - u0); end
        for (int i = 0; i < GS; i++) begin
            step(0, 0, 0);
            if (i == 0) begin
                vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL urun_pulse got %0d exp 1", und_cnt - u0); end
            end
        end
        vectors++; if (cs_cnt - c0 !== 0) begin errors++; $display("FAIL urun_no_cs got %0d exp 0", cs_cnt - c0); end
        vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL urun_single got %0d exp 1", und_cnt - u0); end
    endtask
    task automatic test_drop;
        int d0;
        push_zero(GS);
        d0 = drop_cnt;
        ld_attr(13'h111, 3'd3, 1'b0);
        rom_data = 32'h1234_8421;
        for (int i = 0; i < GS; i++) begin
            if (i == 4) ld_attr(13'h222, 3'd4, 1'b1);
            step(i == 2 || i == 4 || i == 8, i == 6, 0);
            if (i == 4) begin
                vectors++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL drop_wait got %0d exp 1", drop_cnt - d0); end
                vectors++; if (rom_addr !== 13'h111) begin errors++; $display("FAIL drop_addr got %h exp 111", rom_addr); end
                vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL drop_cs got %b exp 1", rom_cs); end
            end
        end
        vectors++; if (drop_cnt - d0 !== 2) begin errors++; $display("FAIL drop_pending got %0d exp 2", drop_cnt - d0); end
        push_part(32'h1234_8421, 1'b0, 3'd3, GS);
    endtask
    task automatic test_race;
        int u0;
        push_zero(GS);
        ld_attr(13'h3C3, 3'd6, 1'b1);
        for (int i = 0; i < GS; i++) step(i == 3, 0, 0);
        rom_data = 32'hF00F_0FF0;
        u0 = und_cnt;
        for (int i = 0; i < GS; i++) begin
            step(0, i == 0, 0);
            if (i == 0) begin
                vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL race_underrun got %0d exp 1", und_cnt - u0); end
            end
        end
        push_part(32'hF00F_0FF0, 1'b1, 3'd6, GS);
    endtask
    task automatic test_blank;
        int u0;
        ld_attr(13'h044, 3'd1, 1'b0);
        rom_data = 32'h5555_00FF;
        u0 = und_cnt;
        for (int i = 0; i < GS; i++) step(i == 1, 0, i == 2);
        push_part(32'h5555_00FF, 1'b0, 3'd1, 4);
        push_zero(2 + L + GS + GS);
        ld_attr(13'h055, 3'd2, 1'b0);
        rom_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            hb = (i >= 4);
            step(i == 2, 0, 0);
            if (i == 2) begin
                vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL blank_cs_pre got %b exp 1", rom_cs); end
            end
            if (i == 4) begin
                vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL blank_cs_flush got %b exp 0", rom_cs); end
            end
        end
        hb = 0;
        vectors++; if (und_cnt - u0 !== 0) begin errors++; $display("FAIL blank_no_underrun got %0d exp 0", und_cnt - u0); end
        for (int i = 0; i < L + GS; i++) step(0, i == 1, 0);
        vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL blank_restart got %0d exp 1", und_cnt - u0); end
        for (int i = 0; i < GS; i++) step(0, 0, 0);
        vectors++; if (und_cnt - u0 !== 2) begin errors++; $display("FAIL blank_ok_ignored got %0d exp 2", und_cnt - u0); end
    endtask
    task automatic test_vb;
        push_zero(GS);
        ld_attr(13'h066, 3'd7, 1'b0);
        rom_data = 32'hFFFF_FFFF;
        for (int i = 0; i < GS; i++) step(i == 1, 0, i == 1);
        cur_pal = 3'd7;
        push_zero(GS);
        vb = 1;
        for (int i = 0; i < GS; i++) step(0, 0, 0);
        vb = 0;
    endtask
`ifdef JTPOPEYE_OBJSHIFT_DBLW_EN
    task automatic test_dblw;
        int u0;
        push_zero(GS);
        ld_attr(13'h077, 3'd4, 1'b0);
        rom_data = 32'h0000_0003;
        for (int i = 0; i < GS; i++) step(i == 0, 0, i == 2);
        push_part(32'h0000_0003, 1'b0, 3'd4, GS);
        u0 = und_cnt;
        for (int i = 0; i < GS; i++) step(0, 0, 0);
        vectors++; if (und_cnt - u0 !== 0) begin errors++; $display("FAIL dblw_group_len got %0d exp 0", und_cnt - u0); end
        push_zero(GS);
        for (int i = 0; i < GS; i++) begin
            step(0, 0, 0);
            if (i == 0) begin
                vectors++; if (und_cnt - u0 !== 1) begin errors++; $display("FAIL dblw_boundary got %0d exp 1", und_cnt - u0); end
            end
        end
    endtask
`endif
    task automatic test_rst_fetch;
        int u0;
        push_zero(1);
        ld_attr(13'h0AA, 3'd1, 1'b0);
        step(1, 0, 0);
        vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL rstf_cs_pre got %b exp 1", rom_cs); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rstf_cs got %b exp 0", rom_cs); end
        vectors++; if (rom_addr !== 13'h0) begin errors++; $display("FAIL rstf_addr got %h exp 0", rom_addr); end
        cur_pal = 3'd0;
        push_zero(L + 2 * GS);
        u0 = und_cnt;
        for (int i = 0; i < L + 2 * GS; i++) step(0, i == 0, 0);
        vectors++; if (und_cnt - u0 !== 2) begin errors++; $display("FAIL rstf_late_ok got %0d exp 2", und_cnt - u0); end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_underrun();
        test_drop();
        test_race();
        test_blank();
        test_vb();
`ifdef JTPOPEYE_OBJSHIFT_DBLW_EN
        test_dblw();
`endif
        test_rst_fetch();
        vectors++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
